// File: rtl/baccarat_pkg.sv
// Shared card types and scoring helpers for the baccarat datapath and FSM.
package baccarat_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_EMPTY = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_TEN   = 4'd10;
  localparam card_t CARD_JACK  = 4'd11;
  localparam card_t CARD_QUEEN = 4'd12;
  localparam card_t CARD_KING  = 4'd13;

  // Tens, faces, empty and the unused codes all count zero.
  function automatic logic [3:0] card_weight(card_t c);
    return (c >= CARD_ACE && c <= 4'd9) ? c : 4'd0;
  endfunction

  function automatic logic [3:0] hand_score(card_t a, card_t b, card_t c);
    logic [4:0] s;
    s = {1'b0, card_weight(a)} + {1'b0, card_weight(b)}
      + {1'b0, card_weight(c)};
    return 4'(s % 5'd10);
  endfunction

endpackage

// File: rtl/baccarat_datapath_card7seg.sv
// Card code to active-low {g,f,e,d,c,b,a} seven-segment pattern.
module card7seg
  import baccarat_pkg::*;
(
  input  card_t      i_card,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'b1111111;
    unique case (i_card)
      CARD_ACE:   o_seg = 7'b0001000;
      4'd2:       o_seg = 7'b0100100;
      4'd3:       o_seg = 7'b0110000;
      4'd4:       o_seg = 7'b0011001;
      4'd5:       o_seg = 7'b0010010;
      4'd6:       o_seg = 7'b0000010;
      4'd7:       o_seg = 7'b1111000;
      4'd8:       o_seg = 7'b0000000;
      4'd9:       o_seg = 7'b0010000;
      CARD_TEN:   o_seg = 7'b1000000;
      CARD_JACK:  o_seg = 7'b1100001;
      CARD_QUEEN: o_seg = 7'b0011000;
      CARD_KING:  o_seg = 7'b0001001;
      default:    o_seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/baccarat_datapath.sv
// Baccarat card datapath: LFSR dealer, six hand registers, scores, displays.
module baccarat_datapath
  import baccarat_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  input  logic       ext_card_en,
  input  logic [3:0] ext_card,
  output logic [3:0] pcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  if (SEED == 8'h00) begin : g_bad_seed
    $error("baccarat_datapath: SEED must be nonzero");
  end

  logic [7:0] r_lfsr;
  card_t      r_pc1, r_pc2, r_pc3;
  card_t      r_dc1, r_dc2, r_dc3;
  logic       w_fb;
  card_t      w_dealt;

  assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // Card is drawn from the LFSR value before this edge's advance.
  assign w_dealt = ext_card_en ? ext_card
                 : 4'(r_lfsr % 8'd13) + 4'd1;

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      r_lfsr <= SEED;
      r_pc1  <= CARD_EMPTY;
      r_pc2  <= CARD_EMPTY;
      r_pc3  <= CARD_EMPTY;
      r_dc1  <= CARD_EMPTY;
      r_dc2  <= CARD_EMPTY;
      r_dc3  <= CARD_EMPTY;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
      if (load_pcard1) r_pc1 <= w_dealt;
      if (load_pcard2) r_pc2 <= w_dealt;
      if (load_pcard3) r_pc3 <= w_dealt;
      if (load_dcard1) r_dc1 <= w_dealt;
      if (load_dcard2) r_dc2 <= w_dealt;
      if (load_dcard3) r_dc3 <= w_dealt;
    end
  end

  assign pcard3 = r_pc3;
  assign pscore = hand_score(r_pc1, r_pc2, r_pc3);
  assign dscore = hand_score(r_dc1, r_dc2, r_dc3);

  card7seg u_hex0 (.i_card(r_pc1), .o_seg(HEX0));
  card7seg u_hex1 (.i_card(r_pc2), .o_seg(HEX1));
  card7seg u_hex2 (.i_card(r_pc3), .o_seg(HEX2));
  card7seg u_hex3 (.i_card(r_dc1), .o_seg(HEX3));
  card7seg u_hex4 (.i_card(r_dc2), .o_seg(HEX4));
  card7seg u_hex5 (.i_card(r_dc3), .o_seg(HEX5));

endmodule

// File: tb/tb_baccarat_datapath.sv
// Scoreboard bench for baccarat_datapath with directed deal vectors.
module tb_baccarat_datapath;

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b0;
  logic       load_pcard1 = 1'b0, load_pcard2 = 1'b0, load_pcard3 = 1'b0;
  logic       load_dcard1 = 1'b0, load_dcard2 = 1'b0, load_dcard3 = 1'b0;
  logic       ext_card_en = 1'b0;
  logic [3:0] ext_card = 4'd0;
  logic [3:0] pcard3, pscore, dscore;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  baccarat_datapath #(.SEED(8'hA5)) dut (
    .slow_clock(slow_clock), .resetb(resetb),
    .load_pcard1(load_pcard1), .load_pcard2(load_pcard2),
    .load_pcard3(load_pcard3), .load_dcard1(load_dcard1),
    .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
    .ext_card_en(ext_card_en), .ext_card(ext_card),
    .pcard3(pcard3), .pscore(pscore), .dscore(dscore),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
    .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  always #5 slow_clock = ~slow_clock;

  typedef struct {
    int         id;
    logic [3:0] cards [6];
    logic [3:0] ps;
    logic [3:0] ds;
  } exp_t;

  exp_t       sb [$];
  int         errors = 0;
  int         checks = 0;
  logic [3:0] m_cards [6];

  function automatic logic [6:0] seg(logic [3:0] c);
    case (c)
      4'd1:    return 7'b0001000;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      4'd10:   return 7'b1000000;
      4'd11:   return 7'b1100001;
      4'd12:   return 7'b0011000;
      4'd13:   return 7'b0001001;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(string nm, int id, logic [6:0] act, logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step%0d %s: got %b expected %b", id, nm, act, exp);
    end
  endtask

  // Monitor: outputs settle after each edge; compare on the falling edge.
  always @(negedge slow_clock) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pcard3", e.id, {3'b0, pcard3}, {3'b0, e.cards[2]});
      chk("pscore", e.id, {3'b0, pscore}, {3'b0, e.ps});
      chk("dscore", e.id, {3'b0, dscore}, {3'b0, e.ds});
      chk("HEX0", e.id, HEX0, seg(e.cards[0]));
      chk("HEX1", e.id, HEX1, seg(e.cards[1]));
      chk("HEX2", e.id, HEX2, seg(e.cards[2]));
      chk("HEX3", e.id, HEX3, seg(e.cards[3]));
      chk("HEX4", e.id, HEX4, seg(e.cards[4]));
      chk("HEX5", e.id, HEX5, seg(e.cards[5]));
    end
  end

  int step_id = 0;

  // ld = {p1,p2,p3,d1,d2,d3}; dealt, ps, ds are hand-computed.
  task automatic step(logic rst, logic [5:0] ld, logic en,
                      logic [3:0] card, logic [3:0] dealt,
                      logic [3:0] ps, logic [3:0] ds);
    exp_t e;
    resetb      = ~rst;
    load_pcard1 = ld[5];
    load_pcard2 = ld[4];
    load_pcard3 = ld[3];
    load_dcard1 = ld[2];
    load_dcard2 = ld[1];
    load_dcard3 = ld[0];
    ext_card_en = en;
    ext_card    = card;
    @(posedge slow_clock);
    #1;
    for (int i = 0; i < 6; i++) begin
      if (rst) m_cards[i] = 4'd0;
      else if (ld[5-i]) m_cards[i] = dealt;
    end
    step_id++;
    e.id    = step_id;
    e.cards = m_cards;
    e.ps    = ps;
    e.ds    = ds;
    sb.push_back(e);
    {load_pcard1, load_pcard2, load_pcard3} = 3'b000;
    {load_dcard1, load_dcard2, load_dcard3} = 3'b000;
  endtask

  initial begin
    for (int i = 0; i < 6; i++) m_cards[i] = 4'd0;
    #1;
    // Reset held two edges, then idle edges with no loads.
    step(1, 6'b000000, 0, 0, 0, 0, 0);
    step(1, 6'b000000, 0, 0, 0, 0, 0);
    step(0, 6'b000000, 0, 0, 0, 0, 0);
    step(0, 6'b000000, 0, 0, 0, 0, 0);
    // Player hand from external cards, then blank code 14.
    step(0, 6'b100000, 1, 9, 9, 9, 0);
    step(0, 6'b010000, 1, 13, 13, 9, 0);
    step(0, 6'b001000, 1, 5, 5, 4, 0);
    step(0, 6'b001000, 1, 14, 14, 9, 0);
    // Dealer hand, then overwrite card 3.
    step(0, 6'b000100, 1, 1, 1, 9, 1);
    step(0, 6'b000010, 1, 1, 1, 9, 2);
    step(0, 6'b000001, 1, 11, 11, 9, 2);
    step(0, 6'b000001, 1, 7, 7, 9, 9);
    // Fresh hands; one card captured by two strobes.
    step(1, 6'b000000, 1, 0, 0, 0, 0);
    step(0, 6'b100100, 1, 7, 7, 7, 7);
    // LFSR deal from seed: A5->10, 4A->10, 95->7.
    step(1, 6'b000000, 0, 0, 0, 0, 0);
    step(0, 6'b100000, 0, 0, 10, 0, 0);
    step(0, 6'b010000, 0, 0, 10, 0, 0);
    step(0, 6'b000100, 0, 0, 7, 0, 7);
    // Mid-deal reset with a strobe high; deal must repeat exactly.
    step(1, 6'b100000, 0, 0, 0, 0, 0);
    step(0, 6'b100000, 0, 0, 10, 0, 0);
    step(0, 6'b010000, 0, 0, 10, 0, 0);
    step(0, 6'b000100, 0, 0, 7, 0, 7);
    repeat (3) @(posedge slow_clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
